// File: rtl/baccarat_pkg.sv
// Shared card codes, dealer FSM states and the card-value / dealer third-card helpers.
package baccarat_pkg;

  localparam logic [3:0] ACE   = 4'd1;
  localparam logic [3:0] TEN   = 4'd10;
  localparam logic [3:0] JACK  = 4'd11;
  localparam logic [3:0] QUEEN = 4'd12;
  localparam logic [3:0] KING  = 4'd13;

  typedef enum logic [3:0] {
    IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, CHECK, DEAL_P3, BCHK, DEAL_D3, RESULT
  } state_t;

  function automatic logic card_valid(input logic [3:0] c);
    return (c >= ACE) && (c <= KING);
  endfunction

  function automatic logic [3:0] card_value(input logic [3:0] c);
    case (c)
      TEN, JACK, QUEEN, KING: return 4'd0;
      default:                return (c > KING) ? 4'd0 : c;
    endcase
  endfunction

  // pdrew=0: dealer stands on 6/7; otherwise the tableau keyed on the player's third card
  function automatic logic dealer_draws(input logic [3:0] ds, input logic pdrew,
                                        input logic [3:0] v);
    if (!pdrew) return ds <= 4'd5;
    case (ds)
      4'd0, 4'd1, 4'd2: return 1'b1;
      4'd3:             return v != 4'd8;
      4'd4:             return (v >= 4'd2) && (v <= 4'd7);
      4'd5:             return (v >= 4'd4) && (v <= 4'd7);
      4'd6:             return (v >= 4'd6) && (v <= 4'd7);
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/baccarat_dealer_hand_total.sv
// Combinational Baccarat hand total: three card codes -> (sum of values) mod 10.
// Zero latency; no flow control.
import baccarat_pkg::*;

module hand_total (
  input  logic [3:0] c1,
  input  logic [3:0] c2,
  input  logic [3:0] c3,
  output logic [3:0] total
);

  logic [4:0] sum;

  always_comb begin
    sum = {1'b0, card_value(c1)} + {1'b0, card_value(c2)} + {1'b0, card_value(c3)};
    if (sum >= 5'd20)      total = 4'(sum - 5'd20);
    else if (sum >= 5'd10) total = 4'(sum - 5'd10);
    else                   total = sum[3:0];
  end

endmodule

// File: rtl/baccarat_dealer.sv
// Baccarat dealer: requests cards (req/vld), deals P1,D1,P2,D2, applies third-card rules.
// Natural -> RESULT 6 cycles after start; stalls while card_vld is low; BACCARAT_STEP_EN gates each card on step.
import baccarat_pkg::*;

module baccarat_dealer (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       start,
  input  logic       step,
  output logic       card_req,
  input  logic       card_vld,
  input  logic [3:0] card_in,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic       round_done,
  output logic       player_win,
  output logic       dealer_win
);

`ifdef BACCARAT_STEP_EN
  localparam logic REQ_ON_ENTRY = 1'b0;
`else
  localparam logic REQ_ON_ENTRY = 1'b1;
  logic step_unused;
  assign step_unused = step;
`endif

  state_t state;
  logic   accept;

  assign accept = card_req && card_vld && card_valid(card_in);

  hand_total u_player (.c1(pcard1), .c2(pcard2), .c3(pcard3), .total(pscore));
  hand_total u_dealer (.c1(dcard1), .c2(dcard2), .c3(dcard3), .total(dscore));

  assign player_win = round_done && (pscore >= dscore);
  assign dealer_win = round_done && (dscore >= pscore);

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state      <= IDLE;
      card_req   <= 1'b0;
      round_done <= 1'b0;
      pcard1 <= '0; pcard2 <= '0; pcard3 <= '0;
      dcard1 <= '0; dcard2 <= '0; dcard3 <= '0;
    end else begin
      case (state)
        IDLE, RESULT: if (start) begin
          pcard1 <= '0; pcard2 <= '0; pcard3 <= '0;
          dcard1 <= '0; dcard2 <= '0; dcard3 <= '0;
          round_done <= 1'b0;
          card_req   <= REQ_ON_ENTRY;
          state      <= DEAL_P1;
        end
        DEAL_P1: if (accept) begin
          pcard1 <= card_in; card_req <= REQ_ON_ENTRY; state <= DEAL_D1;
        end
        DEAL_D1: if (accept) begin
          dcard1 <= card_in; card_req <= REQ_ON_ENTRY; state <= DEAL_P2;
        end
        DEAL_P2: if (accept) begin
          pcard2 <= card_in; card_req <= REQ_ON_ENTRY; state <= DEAL_D2;
        end
        DEAL_D2: if (accept) begin
          dcard2 <= card_in; card_req <= 1'b0; state <= CHECK;
        end
        CHECK: begin
          if (pscore >= 4'd8 || dscore >= 4'd8) begin
            round_done <= 1'b1;
            state      <= RESULT;
          end else if (pscore <= 4'd5) begin
            card_req <= REQ_ON_ENTRY;
            state    <= DEAL_P3;
          end else begin
            state <= BCHK;
          end
        end
        DEAL_P3: if (accept) begin
          pcard3 <= card_in; card_req <= 1'b0; state <= BCHK;
        end
        // an empty pcard3 slot means the player stood
        BCHK: begin
          if (dealer_draws(dscore, pcard3 != 4'd0, card_value(pcard3))) begin
            card_req <= REQ_ON_ENTRY;
            state    <= DEAL_D3;
          end else begin
            round_done <= 1'b1;
            state      <= RESULT;
          end
        end
        DEAL_D3: if (accept) begin
          dcard3 <= card_in; card_req <= 1'b0; round_done <= 1'b1; state <= RESULT;
        end
        default: state <= IDLE;
      endcase
`ifdef BACCARAT_STEP_EN
      if (state inside {DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, DEAL_P3, DEAL_D3} && !card_req && step)
        card_req <= 1'b1;
`endif
    end
  end

endmodule
